// File: rtl/lcd_pkg.sv
// Shared definitions for the HD44780 set-up sequencer and its write strobe:
// control-bit positions, command bytes, wait classes, FSM encodings and the command ROM.
package lcd_pkg;

    localparam int CTRL_RS = 2;
    localparam int CTRL_RW = 1;
    localparam int CTRL_E  = 0;

    localparam logic [7:0] FUNC_WAKE = 8'h30;
    localparam logic [7:0] FUNC_SET  = 8'h38;
    localparam logic [7:0] DISP_OFF  = 8'h08;
    localparam logic [7:0] CLEAR     = 8'h01;
    localparam logic [7:0] ENTRY     = 8'h06;
    localparam logic [7:0] DISP_ON   = 8'h0C;

    localparam logic [2:0] LAST_IDX = 3'd7;

    typedef enum logic [1:0] {
        WAIT_SHORT = 2'd0,
        WAIT_LONG  = 2'd1,
        WAIT_CLEAR = 2'd2
    } wait_class_e;

    typedef enum logic [1:0] {
        ST_PWR_WAIT = 2'd0,
        ST_WRITE    = 2'd1,
        ST_WAIT     = 2'd2,
        ST_DONE     = 2'd3
    } set_up_state_e;

    typedef enum logic [1:0] {
        STB_IDLE  = 2'd0,
        STB_SETUP = 2'd1,
        STB_PULSE = 2'd2,
        STB_HOLD  = 2'd3
    } strobe_state_e;

    typedef struct packed {
        logic [7:0]  cmd;
        wait_class_e cls;
    } rom_entry_t;

    function automatic rom_entry_t rom_lookup(input logic [2:0] idx);
        rom_entry_t e;
        case (idx)
            3'd0:    e = '{cmd: FUNC_WAKE, cls: WAIT_LONG};
            3'd1:    e = '{cmd: FUNC_WAKE, cls: WAIT_SHORT};
            3'd2:    e = '{cmd: FUNC_WAKE, cls: WAIT_SHORT};
            3'd3:    e = '{cmd: FUNC_SET,  cls: WAIT_SHORT};
            3'd4:    e = '{cmd: DISP_OFF,  cls: WAIT_SHORT};
            3'd5:    e = '{cmd: CLEAR,     cls: WAIT_CLEAR};
            3'd6:    e = '{cmd: ENTRY,     cls: WAIT_SHORT};
            default: e = '{cmd: DISP_ON,   cls: WAIT_SHORT};
        endcase
        return e;
    endfunction

    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    // Counter holds N-1, so $clog2(N) bits suffice; keep at least one bit.
    function automatic int cnt_width(input int max_cyc);
        return (max_cyc < 2) ? 1 : $clog2(max_cyc);
    endfunction

endpackage

// File: rtl/lcd_write_strobe.sv
// One LCD bus write: byte/RS/RW presented for SETUP_CYC, E high for EN_HIGH_CYC,
// then held for HOLD_CYC. A new write may be accepted in the last hold cycle.
module lcd_write_strobe
    import lcd_pkg::*;
#(
    parameter int SETUP_CYC   = 10,
    parameter int EN_HIGH_CYC = 25,
    parameter int HOLD_CYC    = 10,
    parameter int CNT_W       = 5
) (
    input  logic       clk,
    input  logic       rstN,
    input  logic       go,
    input  logic       clr,
    input  logic       rs,
    input  logic       rw,
    input  logic [7:0] wr_byte,
    output logic [2:0] ctrl,
    output logic [7:0] data,
    output logic       last
);

    strobe_state_e    state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       ctrl_q, ctrl_d;
    logic [7:0]       data_q, data_d;
    logic             accept;

    // E is a flop with async clear so it drops the instant reset asserts.
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            state_q <= STB_IDLE;
            cnt_q   <= '0;
            ctrl_q  <= '0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ctrl_q  <= ctrl_d;
            data_q  <= data_d;
        end
    end

    always_comb begin
        last    = (state_q == STB_HOLD) && (cnt_q == '0);
        accept  = go && ((state_q == STB_IDLE) || last);
        state_d = state_q;
        cnt_d   = (cnt_q == '0) ? '0 : cnt_q - 1'b1;
        case (state_q)
            STB_IDLE: begin
                if (accept) begin
                    state_d = STB_SETUP;
                    cnt_d   = CNT_W'(SETUP_CYC - 1);
                end
            end
            STB_SETUP: begin
                if (cnt_q == '0) begin
                    state_d = STB_PULSE;
                    cnt_d   = CNT_W'(EN_HIGH_CYC - 1);
                end
            end
            STB_PULSE: begin
                if (cnt_q == '0) begin
                    state_d = STB_HOLD;
                    cnt_d   = CNT_W'(HOLD_CYC - 1);
                end
            end
            STB_HOLD: begin
                if (cnt_q == '0) begin
                    if (accept) begin
                        state_d = STB_SETUP;
                        cnt_d   = CNT_W'(SETUP_CYC - 1);
                    end else begin
                        state_d = STB_IDLE;
                    end
                end
            end
            default: state_d = STB_IDLE;
        endcase
    end

    // Bus value only changes when a write is accepted, i.e. on SETUP entry.
    always_comb begin
        ctrl_d = ctrl_q;
        data_d = data_q;
        if (clr) begin
            ctrl_d = '0;
            data_d = '0;
        end else if (accept) begin
            data_d          = wr_byte;
            ctrl_d[CTRL_RS] = rs;
            ctrl_d[CTRL_RW] = rw;
        end
        ctrl_d[CTRL_E] = (state_d == STB_PULSE);
    end

    assign ctrl = ctrl_q;
    assign data = data_q;

endmodule

// File: rtl/lcd_set_up.sv
// Power-on initialisation sequencer for an HD44780 panel in 8-bit mode: waits out
// power-up, writes the 8-entry command ROM with per-command execution waits, then hands off.
module lcd_set_up
    import lcd_pkg::*;
#(
    parameter int POWER_UP_CYC   = 1_500_000,
    parameter int SETUP_CYC      = 10,
    parameter int EN_HIGH_CYC    = 25,
    parameter int HOLD_CYC       = 10,
    parameter int SHORT_WAIT_CYC = 4_000,
    parameter int LONG_WAIT_CYC  = 410_000,
    parameter int CLEAR_WAIT_CYC = 164_000
) (
    input  logic       clk,
    input  logic       rstN,
    input  logic       start,
    output logic [2:0] ctrlLcdSetUp,
    output logic [7:0] dataLcdSetUp,
    output logic       busy,
    output logic       setUpDone
);

    localparam int MAX_CYC = max2(max2(max2(POWER_UP_CYC, LONG_WAIT_CYC),
                                       max2(CLEAR_WAIT_CYC, SHORT_WAIT_CYC)),
                                  max2(max2(SETUP_CYC, EN_HIGH_CYC), HOLD_CYC));
    localparam int CNT_W = cnt_width(MAX_CYC);

    set_up_state_e    state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       idx_q, idx_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             go;
    logic             stb_last;
    logic [CNT_W-1:0] wait_load;
    rom_entry_t       cur_entry;
    rom_entry_t       next_entry;

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            state_q <= ST_PWR_WAIT;
            cnt_q   <= CNT_W'(POWER_UP_CYC - 1);
            idx_q   <= '0;
            busy_q  <= 1'b1;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        cur_entry = rom_lookup(idx_q);
        case (cur_entry.cls)
            WAIT_LONG:  wait_load = CNT_W'(LONG_WAIT_CYC - 1);
            WAIT_CLEAR: wait_load = CNT_W'(CLEAR_WAIT_CYC - 1);
            default:    wait_load = CNT_W'(SHORT_WAIT_CYC - 1);
        endcase
    end

    // WRITE covers SETUP/PULSE/HOLD inside the strobe; its last hold cycle hands back here.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        cnt_d   = (cnt_q == '0) ? '0 : cnt_q - 1'b1;
        go      = 1'b0;
        case (state_q)
            ST_PWR_WAIT: begin
                if (cnt_q == '0) begin
                    state_d = ST_WRITE;
                    idx_d   = '0;
                    go      = 1'b1;
                end
            end
            ST_WRITE: begin
                if (stb_last) begin
                    state_d = ST_WAIT;
                    cnt_d   = wait_load;
                end
            end
            ST_WAIT: begin
                if (cnt_q == '0) begin
                    if (idx_q == LAST_IDX) begin
                        state_d = ST_DONE;
                    end else begin
                        state_d = ST_WRITE;
                        idx_d   = idx_q + 1'b1;
                        go      = 1'b1;
                    end
                end
            end
            ST_DONE: begin
                if (start) begin
                    state_d = ST_WRITE;
                    idx_d   = '0;
                    go      = 1'b1;
                end
            end
            default: state_d = ST_PWR_WAIT;
        endcase
    end

    always_comb begin
        next_entry = rom_lookup(idx_d);
        busy_d     = (state_d != ST_DONE);
        done_d     = (state_d == ST_DONE);
    end

    lcd_write_strobe #(
        .SETUP_CYC  (SETUP_CYC),
        .EN_HIGH_CYC(EN_HIGH_CYC),
        .HOLD_CYC   (HOLD_CYC),
        .CNT_W      (CNT_W)
    ) u_strobe (
        .clk    (clk),
        .rstN   (rstN),
        .go     (go),
        .clr    (state_d == ST_DONE),
        .rs     (1'b0),
        .rw     (1'b0),
        .wr_byte(next_entry.cmd),
        .ctrl   (ctrlLcdSetUp),
        .data   (dataLcdSetUp),
        .last   (stb_last)
    );

    assign busy      = busy_q;
    assign setUpDone = done_q;

endmodule
